// File: rtl/seq_word_adder_pkg.sv
// Shared types and constants for the byte-serial word adder.
package seq_word_adder_pkg;

    localparam int unsigned BYTE_W = 8;

    typedef enum logic {
        IDLE,
        BUSY
    } state_e;

    typedef struct packed {
        logic [BYTE_W-1:0] sum;
        logic              cout;
        logic              c7;
    } core_res_t;

endpackage

// File: rtl/seq_word_adder_prefix8_core.sv
// Combinational 8-bit Kogge-Stone adder with carry-in; exposes the carry into bit 7
// so the caller can derive signed overflow.
module prefix8_core
    import seq_word_adder_pkg::*;
(
    input  logic [BYTE_W-1:0] a_i,
    input  logic [BYTE_W-1:0] b_i,
    input  logic              cin_i,
    output core_res_t         res_o
);

    logic [BYTE_W-1:0] g0, p0, g1, p1, g2, p2, g3, p3;
    logic [BYTE_W:0]   c;

    assign g0 = a_i & b_i;
    assign p0 = a_i ^ b_i;

    // Three prefix levels with spans 1, 2, 4 give group (g,p) over bits [i:0].
    for (genvar i = 0; i < BYTE_W; i++) begin : g_prefix
        if (i >= 1) begin : g_l1
            assign g1[i] = g0[i] | (p0[i] & g0[i-1]);
            assign p1[i] = p0[i] & p0[i-1];
        end else begin : g_l1_pass
            assign g1[i] = g0[i];
            assign p1[i] = p0[i];
        end
        if (i >= 2) begin : g_l2
            assign g2[i] = g1[i] | (p1[i] & g1[i-2]);
            assign p2[i] = p1[i] & p1[i-2];
        end else begin : g_l2_pass
            assign g2[i] = g1[i];
            assign p2[i] = p1[i];
        end
        if (i >= 4) begin : g_l3
            assign g3[i] = g2[i] | (p2[i] & g2[i-4]);
            assign p3[i] = p2[i] & p2[i-4];
        end else begin : g_l3_pass
            assign g3[i] = g2[i];
            assign p3[i] = p2[i];
        end
        assign c[i+1] = g3[i] | (p3[i] & cin_i);
    end

    assign c[0]       = cin_i;
    assign res_o.sum  = p0 ^ c[BYTE_W-1:0];
    assign res_o.cout = c[BYTE_W];
    assign res_o.c7   = c[BYTE_W-1];

endmodule

// File: rtl/seq_word_adder.sv
// Byte-serial multi-byte adder/subtractor: LSB-first operand bytes in, one registered
// sum byte out per input byte, with word carry-out and signed overflow on the last byte.
module seq_word_adder
    import seq_word_adder_pkg::*;
#(
    parameter int unsigned NBYTES = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [BYTE_W-1:0] in_a,
    input  logic [BYTE_W-1:0] in_b,
    input  logic              in_sub,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [BYTE_W-1:0] out_sum,
    output logic              out_last,
    output logic              out_cout,
    output logic              out_ovf
);

    localparam int unsigned     CntW    = (NBYTES > 1) ? $clog2(NBYTES) : 1;
    localparam logic [CntW-1:0] LastCnt = CntW'(NBYTES - 1);

    state_e            state_q, state_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic              carry_q, carry_d;
    logic              sub_q, sub_d;
    logic              out_valid_q, out_valid_d;
    logic [BYTE_W-1:0] out_sum_q, out_sum_d;
    logic              out_last_q, out_last_d;
    logic              out_cout_q, out_cout_d;
    logic              out_ovf_q, out_ovf_d;

    logic              in_fire, is_first, is_last, sub_eff, cin;
    logic [BYTE_W-1:0] b_eff;
    core_res_t         res;

    // A drain in the same cycle frees the single output slot for a new byte.
    assign in_ready = ~out_valid_q | out_ready;
    assign in_fire  = in_valid & in_ready;
    assign is_first = (state_q == IDLE);
    assign is_last  = (cnt_q == LastCnt);

    always_comb begin
        sub_eff = sub_q;
        cin     = carry_q;
        if (is_first) begin
            sub_eff = in_sub;
            cin     = in_sub;
        end
        b_eff = in_b ^ {BYTE_W{sub_eff}};
    end

    prefix8_core u_core (
        .a_i   (in_a),
        .b_i   (b_eff),
        .cin_i (cin),
        .res_o (res)
    );

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        carry_d     = carry_q;
        sub_d       = sub_q;
        out_valid_d = out_valid_q & ~out_ready;
        out_sum_d   = out_sum_q;
        out_last_d  = out_last_q;
        out_cout_d  = out_cout_q;
        out_ovf_d   = out_ovf_q;
        if (in_fire) begin
            cnt_d       = is_last ? '0 : cnt_q + 1'b1;
            state_d     = is_last ? IDLE : BUSY;
            carry_d     = is_last ? 1'b0 : res.cout;
            if (is_first) begin
                sub_d = in_sub;
            end
            out_valid_d = 1'b1;
            out_sum_d   = res.sum;
            out_last_d  = is_last;
            out_cout_d  = is_last & res.cout;
            out_ovf_d   = is_last & (res.c7 ^ res.cout);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            carry_q     <= 1'b0;
            sub_q       <= 1'b0;
            out_valid_q <= 1'b0;
            out_sum_q   <= '0;
            out_last_q  <= 1'b0;
            out_cout_q  <= 1'b0;
            out_ovf_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            carry_q     <= carry_d;
            sub_q       <= sub_d;
            out_valid_q <= out_valid_d;
            out_sum_q   <= out_sum_d;
            out_last_q  <= out_last_d;
            out_cout_q  <= out_cout_d;
            out_ovf_q   <= out_ovf_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_sum   = out_sum_q;
    assign out_last  = out_last_q;
    assign out_cout  = out_cout_q;
    assign out_ovf   = out_ovf_q;

endmodule

// File: tb/tb_seq_word_adder.sv
// Directed bench for seq_word_adder with NBYTES=4: vector table plus backpressure and reset.
module tb_seq_word_adder;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       sub;
        logic [7:0] sum;
        logic       last;
        logic       cout;
        logic       ovf;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] in_a = 8'h00;
    logic [7:0] in_b = 8'h00;
    logic       in_sub = 1'b0;
    logic       out_valid;
    logic       out_ready = 1'b1;
    logic [7:0] out_sum;
    logic       out_last;
    logic       out_cout;
    logic       out_ovf;

    int errors = 0;
    int checks = 0;

    vec_t vecs[20];

    seq_word_adder #(
        .NBYTES(4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_sub    (in_sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_last  (out_last),
        .out_cout  (out_cout),
        .out_ovf   (out_ovf)
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(logic [7:0] a, logic [7:0] b, logic sub, logic [7:0] sum,
                                logic last, logic cout, logic ovf);
        vec_t v;
        v.a = a; v.b = b; v.sub = sub; v.sum = sum;
        v.last = last; v.cout = cout; v.ovf = ovf;
        return v;
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_out(string tag, vec_t v);
        chk({tag, " out_valid"}, 32'(out_valid), 32'd1);
        chk({tag, " out_sum"},   32'(out_sum),   32'(v.sum));
        chk({tag, " out_last"},  32'(out_last),  32'(v.last));
        chk({tag, " out_cout"},  32'(out_cout),  32'(v.cout));
        chk({tag, " out_ovf"},   32'(out_ovf),   32'(v.ovf));
    endtask

    // Present one byte pair at the negedge, wait (bounded) for acceptance, return #1 after.
    task automatic send(vec_t v);
        int waited = 0;
        @(negedge clk);
        in_valid = 1'b1;
        in_a     = v.a;
        in_b     = v.b;
        in_sub   = v.sub;
        while (!in_ready && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        if (!in_ready) begin
            chk("send in_ready timeout", 32'(in_ready), 32'd1);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    initial begin
        // 0x000000FF + 0x00000001
        vecs[0]  = mk(8'hFF, 8'h01, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        vecs[1]  = mk(8'h00, 8'h00, 1'b0, 8'h01, 1'b0, 1'b0, 1'b0);
        vecs[2]  = mk(8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        vecs[3]  = mk(8'h00, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        // 0xFFFFFFFF + 0x00000001
        vecs[4]  = mk(8'hFF, 8'h01, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        vecs[5]  = mk(8'hFF, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        vecs[6]  = mk(8'hFF, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        vecs[7]  = mk(8'hFF, 8'h00, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0);
        // 0x7FFFFFFF + 0x00000001
        vecs[8]  = mk(8'hFF, 8'h01, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        vecs[9]  = mk(8'hFF, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        vecs[10] = mk(8'hFF, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        vecs[11] = mk(8'h7F, 8'h00, 1'b0, 8'h80, 1'b1, 1'b0, 1'b1);
        // 0x00000005 - 0x00000007; in_sub low on later bytes must be ignored
        vecs[12] = mk(8'h05, 8'h07, 1'b1, 8'hFE, 1'b0, 1'b0, 1'b0);
        vecs[13] = mk(8'h00, 8'h00, 1'b0, 8'hFF, 1'b0, 1'b0, 1'b0);
        vecs[14] = mk(8'h00, 8'h00, 1'b0, 8'hFF, 1'b0, 1'b0, 1'b0);
        vecs[15] = mk(8'h00, 8'h00, 1'b0, 8'hFF, 1'b1, 1'b0, 1'b0);
        // 1 + 1 right after the borrow word; in_sub high on later bytes must be ignored
        vecs[16] = mk(8'h01, 8'h01, 1'b0, 8'h02, 1'b0, 1'b0, 1'b0);
        vecs[17] = mk(8'h00, 8'h00, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0);
        vecs[18] = mk(8'h00, 8'h00, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0);
        vecs[19] = mk(8'h00, 8'h00, 1'b1, 8'h00, 1'b1, 1'b0, 1'b0);

        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk("reset out_valid", 32'(out_valid), 32'd0);
        chk("reset out_sum",   32'(out_sum),   32'd0);
        chk("reset out_last",  32'(out_last),  32'd0);
        chk("reset out_cout",  32'(out_cout),  32'd0);
        chk("reset out_ovf",   32'(out_ovf),   32'd0);
        chk("reset in_ready",  32'(in_ready),  32'd1);

        for (int i = 0; i < 20; i++) begin
            send(vecs[i]);
            check_out($sformatf("vec%0d", i), vecs[i]);
        end

        // Backpressure: 0x00000102 + 0x00000304, stall 3 cycles after byte 1
        send(mk(8'h02, 8'h04, 1'b0, 8'h06, 1'b0, 1'b0, 1'b0));
        check_out("bp b0", mk(8'h02, 8'h04, 1'b0, 8'h06, 1'b0, 1'b0, 1'b0));
        send(mk(8'h01, 8'h03, 1'b0, 8'h04, 1'b0, 1'b0, 1'b0));
        check_out("bp b1", mk(8'h01, 8'h03, 1'b0, 8'h04, 1'b0, 1'b0, 1'b0));
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_a      = 8'h00;
        in_b      = 8'h00;
        in_sub    = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk($sformatf("bp stall%0d in_ready", k), 32'(in_ready), 32'd0);
            chk($sformatf("bp stall%0d out_valid", k), 32'(out_valid), 32'd1);
            chk($sformatf("bp stall%0d out_sum", k), 32'(out_sum), 32'h04);
            chk($sformatf("bp stall%0d out_last", k), 32'(out_last), 32'd0);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        check_out("bp b2", mk(8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0));
        send(mk(8'h00, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0));
        check_out("bp b3", mk(8'h00, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0));
        @(posedge clk);
        #1;
        chk("bp drained out_valid", 32'(out_valid), 32'd0);

        // Reset mid-word: three bytes of 7-5 leave carry=1 and sub=1 pending
        send(mk(8'h07, 8'h05, 1'b1, 8'h02, 1'b0, 1'b0, 1'b0));
        check_out("rst b0", mk(8'h07, 8'h05, 1'b1, 8'h02, 1'b0, 1'b0, 1'b0));
        send(mk(8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0));
        send(mk(8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0));
        check_out("rst b2", mk(8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0));
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("post-rst out_valid", 32'(out_valid), 32'd0);
        chk("post-rst in_ready",  32'(in_ready),  32'd1);
        send(mk(8'h03, 8'h04, 1'b0, 8'h07, 1'b0, 1'b0, 1'b0));
        check_out("fresh b0", mk(8'h03, 8'h04, 1'b0, 8'h07, 1'b0, 1'b0, 1'b0));
        send(mk(8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0));
        check_out("fresh b1", mk(8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0));
        send(mk(8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0));
        check_out("fresh b2", mk(8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0));
        send(mk(8'h00, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0));
        check_out("fresh b3", mk(8'h00, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/seq_word_adder.md
# seq_word_adder

Byte-serial multi-byte adder/subtractor built around the 8-bit parallel-prefix adder. It accepts operand bytes LSB-first over a valid/ready stream and keeps the carry between bytes in a register. It emits one registered sum byte per accepted input byte, and flags carry-out and signed overflow on the last byte of each word. It sits directly downstream of the operand pins and wraps the prefix8 adder datapath so that words wider than 8 bits can be added.

## Interface
Parameters:
- NBYTES, 4: bytes per word (≥2); byte counter width is $clog2(NBYTES)

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  operand byte pair valid
- in_ready  out  1  block can accept a byte pair this cycle
- in_a  in  8  operand A byte
- in_b  in  8  operand B byte
- in_sub  in  1  1 = compute A−B; sampled only on byte 0 of a word
- out_valid  out  1  out_sum etc. valid
- out_ready  in  1  consumer accepts output this cycle
- out_sum  out  8  result byte
- out_last  out  1  out_sum is byte NBYTES−1 of its word
- out_cout  out  1  word carry-out (sub: 1 = no borrow); valid only with out_last
- out_ovf  out  1  signed two's-complement overflow; valid only with out_last

## Operation
- Transfers occur on valid&ready at each port.
- Byte counter `cnt` runs 0..NBYTES−1 and advances per input transfer. It wraps to 0 after NBYTES−1.
- FSM states:
  - IDLE (cnt==0): the next input transfer is byte 0.
  - BUSY (cnt≠0): mid-word.
  - IDLE→BUSY on a byte-0 transfer; BUSY→IDLE on a byte NBYTES−1 transfer.
- On a byte-0 transfer: `sub_q <= in_sub`. Effective carry-in = in_sub. B operand = in_b ^ {8{in_sub}}.
- On a later byte transfer: carry-in = `carry_q`, B operand = in_b ^ {8{sub_q}}; in_sub is ignored.
- Sum byte and carry come from the prefix8 core: 8-bit + 8-bit + cin gives 8-bit sum, cout, and c7 (the carry into bit 7).
- Each transfer updates `carry_q <= cout`.
- On the last byte:
  - out_cout = cout
  - out_ovf = c7 ^ cout
  - out_last = 1
  - carry_q is cleared.
- On non-last bytes, out_cout and out_ovf are 0.
- Output register: 1-entry. in_ready = !out_valid | out_ready (same-cycle pass-through of a drain).
- Holding: while out_valid & !out_ready, all out_* signals hold stable.

## Timing
- Latency: 1 cycle, input transfer at edge N → out_valid from edge N.
- Throughput: 1 byte/cycle with out_ready tied high. One word takes NBYTES cycles.
- Reset values: out_valid=0, out_sum=0, out_last=0, out_cout=0, out_ovf=0, cnt=0, carry_q=0, sub_q=0, state IDLE.
- in_ready is 1 in the cycle after reset.
- Reset mid-word: the partial word and any pending output are discarded, and the next transfer is byte 0.
- Simultaneous output drain and input accept: the new result is loaded and out_valid stays 1.
- in_valid with in_ready=0: no state change. The source must hold its data.

## Structure
- Package seq_word_adder_pkg holds:
  - BYTE_W=8
  - the FSM state enum {IDLE, BUSY}
  - a typedef for the core result struct {sum[7:0], cout, c7}
- Sub-module prefix8_core: purely combinational 8-bit Kogge-Stone adder with cin, outputs sum/cout/c7. It is instantiated once.
- The top level holds the counter, FSM, carry/sub registers and output register.

## Test plan
All cases use NBYTES=4; byte values are listed LSB-first.
- 0x000000FF + 0x00000001, add, out_ready=1 → sums 00,01,00,00. out_last only on the 4th byte; cout=0, ovf=0.
- 0xFFFFFFFF + 0x00000001 → 00,00,00,00. Last byte: cout=1, ovf=0.
- 0x7FFFFFFF + 0x00000001 → 00,00,00,80. Last byte: cout=0, ovf=1.
- Subtract, 0x00000005 − 0x00000007 → FE,FF,FF,FF. Last byte: cout=0 (borrow), ovf=0. The next add word then starts with cin=0.
- Backpressure: out_ready=0 for 3 cycles after byte 1 →
  - in_ready=0 during the stall, and out_sum/out_last stay stable;
  - the word completes correctly after release with no byte lost or duplicated.
- rst pulse after byte 2 of a word →
  - out_valid=0 the next cycle;
  - a fresh word 0x00000003 + 0x00000004 then gives 07,00,00,00 (no stale carry or sub).
